// File: rtl/config_frame_loader_pkg.sv
// Shared constants for the configuration frame loader: header layout, opcodes, FSM encodings.
package config_frame_loader_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [7:0] SYNC_BYTE = 8'hFA;

  localparam int unsigned SYNC_MSB = 31;
  localparam int unsigned SYNC_LSB = 24;
  localparam int unsigned OP_MSB   = 23;
  localparam int unsigned OP_LSB   = 20;
  localparam int unsigned IDX_MSB  = 7;
  localparam int unsigned IDX_LSB  = 0;

  typedef enum logic [3:0] {
    OP_WRITE_FRAME = 4'h1,
    OP_END         = 4'h2,
    OP_CLR_ERR     = 4'h3
  } opcode_e;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_LOAD   = S_LOAD,
    ST_SETUP  = S_SETUP,
    ST_STROBE = S_STROBE,
    ST_HOLD   = S_HOLD
  } state_e;

endpackage

// File: rtl/config_frame_loader_if.sv
// Command/data word stream from the bitstream source into the frame loader.
interface config_frame_loader_if;
  import config_frame_loader_pkg::*;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/frame_strobe_decoder.sv
// Registered frame index to one-hot FrameStrobe decode, gated by an enable.
module frame_strobe_decoder #(
  parameter int unsigned MaxFramesPerCol = 20
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       en_i,
  input  logic [7:0]                 idx_i,
  output logic [MaxFramesPerCol-1:0] strobe_o
);

  logic [MaxFramesPerCol-1:0] strobe_d;
  logic [MaxFramesPerCol-1:0] strobe_q;

  always_comb begin
    strobe_d = '0;
    for (int unsigned i = 0; i < MaxFramesPerCol; i++) begin
      strobe_d[i] = en_i && (idx_i == 8'(i));
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/config_frame_loader.sv
// Assembles one column frame from a word stream and strobes it into the ConfigMem latches.
// Optional build macro CONFIG_FRAME_CHECKSUM_EN adds a trailing XOR checksum word per frame.
module config_frame_loader
  import config_frame_loader_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumRows         = 4,
  parameter int unsigned StrobeCycles    = 2
) (
  input  logic                                CLK,
  input  logic                                resetn,
  config_frame_loader_if.slave                s,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
  output logic [MaxFramesPerCol-1:0]          FrameStrobe,
  output logic                                busy,
  output logic                                error,
  output logic                                done
);

`ifdef CONFIG_FRAME_CHECKSUM_EN
  localparam int unsigned LoadWords = NumRows + 1;
`else
  localparam int unsigned LoadWords = NumRows;
`endif
  localparam int unsigned RW = $clog2(LoadWords + 1);
  localparam int unsigned SW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

  state_e                             state_q, state_d;
  logic [RW-1:0]                      row_q, row_d;
  logic [7:0]                         idx_q, idx_d;
  logic                               idx_ok_q, idx_ok_d;
  logic [SW-1:0]                      scnt_q, scnt_d;
  logic [NumRows*FrameBitsPerRow-1:0] data_q, data_d;
  logic [FrameBitsPerRow-1:0]         csum_q, csum_d;
  logic                               err_q, err_d;
  logic                               done_q, done_d;
  logic                               rdy_q;
  logic                               busy_q;

  logic                               accept;
  logic                               last_ok;
  logic [7:0]                         hdr_idx;
  logic                               hdr_idx_ok;
  logic [FrameBitsPerRow-1:0]         word_bits;

  assign accept     = s.s_valid & rdy_q;
  assign hdr_idx    = s.s_data[IDX_MSB:IDX_LSB];
  assign hdr_idx_ok = 32'(hdr_idx) < MaxFramesPerCol;
  assign word_bits  = s.s_data[FrameBitsPerRow-1:0];

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    idx_d    = idx_q;
    idx_ok_d = idx_ok_q;
    scnt_d   = scnt_q;
    data_d   = data_q;
    csum_d   = csum_q;
    err_d    = err_q;
    done_d   = 1'b0;
    last_ok  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (s.s_data[SYNC_MSB:SYNC_LSB] != SYNC_BYTE) begin
            err_d = 1'b1;
          end else begin
            case (s.s_data[OP_MSB:OP_LSB])
              OP_WRITE_FRAME: begin
                idx_d    = hdr_idx;
                idx_ok_d = hdr_idx_ok;
                if (!hdr_idx_ok) err_d = 1'b1;
                row_d    = '0;
                csum_d   = '0;
                state_d  = ST_LOAD;
              end
              OP_END:     done_d = 1'b1;
              OP_CLR_ERR: err_d  = 1'b0;
              default:    err_d  = 1'b1;
            endcase
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // Constant-index row select keeps the write decode a plain mux per row.
          for (int unsigned r = 0; r < NumRows; r++) begin
            if (row_q == RW'(r)) begin
              data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = word_bits;
              csum_d = csum_q ^ word_bits;
            end
          end
          row_d = row_q + RW'(1);
          if (row_q == RW'(LoadWords - 1)) begin
            last_ok = idx_ok_q;
`ifdef CONFIG_FRAME_CHECKSUM_EN
            if (word_bits != csum_q) begin
              last_ok = 1'b0;
              err_d   = 1'b1;
            end
`endif
            state_d = last_ok ? ST_SETUP : ST_IDLE;
          end
        end
      end
      ST_SETUP: begin
        scnt_d  = '0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (scnt_q == SW'(StrobeCycles - 1)) begin
          state_d = ST_HOLD;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      ST_HOLD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      idx_q    <= '0;
      idx_ok_q <= 1'b0;
      scnt_q   <= '0;
      data_q   <= '0;
      csum_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      idx_q    <= idx_d;
      idx_ok_q <= idx_ok_d;
      scnt_q   <= scnt_d;
      data_q   <= data_d;
      csum_q   <= csum_d;
      err_q    <= err_d;
      done_q   <= done_d;
      rdy_q    <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  // Decoder registers off next-state so the strobe aligns with the STROBE state itself.
  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_strobe_dec (
    .CLK      (CLK),
    .resetn   (resetn),
    .en_i     (state_d == ST_STROBE),
    .idx_i    (idx_q),
    .strobe_o (FrameStrobe)
  );

  assign s.s_ready = rdy_q;
  assign FrameData = data_q;
  assign busy      = busy_q;
  assign error     = err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// Scoreboard bench for config_frame_loader: stimulus pushes expected strobe/done events, a monitor pops them.
module tb_config_frame_loader;

  logic         CLK = 1'b0;
  logic         resetn;
  logic [127:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         busy, error, done;

  config_frame_loader_if bus ();

  config_frame_loader #(
    .MaxFramesPerCol(20),
    .FrameBitsPerRow(32),
    .NumRows        (4),
    .StrobeCycles   (2)
  ) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .s          (bus),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .busy       (busy),
    .error      (error),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit           is_done;
    logic [19:0]  strobe;
    logic [127:0] data;
    int           start;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever a done pulse or a strobe burst appears.
  exp_t        mon_e;
  logic [19:0] prev_strobe = '0;
  int          run_len = 0;
  always @(negedge CLK) begin
    if (!resetn) begin
      prev_strobe = '0;
      run_len     = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) check("done_unexpected", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("done_kind", 1, mon_e.is_done);
        end
      end
      if (FrameStrobe != '0 && prev_strobe == '0) begin
        if (sb.size() == 0) check("strobe_unexpected", FrameStrobe, 0);
        else begin
          mon_e = sb.pop_front();
          check("strobe_kind", 0, mon_e.is_done);
          check("strobe_onehot", FrameStrobe, mon_e.strobe);
          check("strobe_data", FrameData, mon_e.data);
          check("strobe_start", cyc, mon_e.start);
        end
        run_len = 0;
      end
      if (FrameStrobe != '0) begin
        run_len++;
        check("ready_low_in_strobe", bus.s_ready, 0);
      end
      if (FrameStrobe == '0 && prev_strobe != '0) check("strobe_len", run_len, 2);
      prev_strobe = FrameStrobe;
    end
  end

  task automatic send(input logic [31:0] w, input int gap, output int edge_n);
    logic rdy;
    edge_n = -1;
    repeat (gap) @(negedge CLK);
    @(negedge CLK);
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    for (int k = 0; k < 50; k++) begin
      rdy = bus.s_ready;
      @(posedge CLK);
      #1;
      if (rdy) begin
        edge_n = cyc;
        break;
      end
      @(negedge CLK);
    end
    bus.s_valid = 1'b0;
    if (edge_n < 0) check("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [7:0] idx, input logic [31:0] rows[4], input int gaps[4],
                            input bit corrupt, input bit expect_strobe, output int last);
    int          e;
    logic [31:0] x;
    exp_t        ex;
    x = '0;
    send({8'hFA, 4'h1, 12'h000, idx}, 0, e);
    for (int r = 0; r < 4; r++) begin
      send(rows[r], gaps[r], e);
      x = x ^ rows[r];
    end
`ifdef CONFIG_FRAME_CHECKSUM_EN
    send(x ^ {31'd0, corrupt}, 0, e);
`endif
    last = e;
    if (expect_strobe) begin
      ex.is_done = 1'b0;
      ex.strobe  = 20'd1 << idx;
      ex.data    = {rows[3], rows[2], rows[1], rows[0]};
      ex.start   = last + 1;
      sb.push_back(ex);
    end
  endtask

  task automatic check_ready_window();
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("ready_window", bus.s_ready, (k == 4));
      check("busy_window", busy, (k != 4));
    end
  endtask

  logic [31:0] rows_a[4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0] rows_b[4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F};
  logic [31:0] rows_c[4] = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004};
  int          no_gap[4] = '{0, 0, 0, 0};
  int          gaps_b[4] = '{2, 0, 3, 1};

  initial begin
    int   e, last;
    exp_t ex;
    resetn      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (2) @(negedge CLK);
    check("rst_FrameData", FrameData, 0);
    check("rst_FrameStrobe", FrameStrobe, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_done", done, 0);
    check("rst_s_ready", bus.s_ready, 0);
    resetn = 1'b1;
    @(posedge CLK);
    #1;
    check("ready_after_reset", bus.s_ready, 1);

    // Nominal frame, index 5, back-to-back rows.
    send_frame(8'd5, rows_a, no_gap, 1'b0, 1'b1, last);
    check_ready_window();
    check("data_kept_after_hold", FrameData, 128'h44444444_33333333_22222222_11111111);

    // Bad sync, then clear.
    send(32'hAB100003, 0, e);
    @(negedge CLK);
    check("badsync_error", error, 1);
    check("badsync_ready", bus.s_ready, 1);
    send(32'hFA300000, 0, e);
    @(negedge CLK);
    check("clr_err", error, 0);

    // Unknown opcode.
    send(32'hFA700000, 0, e);
    @(negedge CLK);
    check("badop_error", error, 1);
    send(32'hFA300000, 0, e);

    // Illegal index 25: rows consumed, no strobe.
    send_frame(8'd25, rows_c, no_gap, 1'b0, 1'b0, last);
    @(negedge CLK);
    check("badidx_error", error, 1);
    check("badidx_busy", busy, 0);
    check("badidx_ready", bus.s_ready, 1);
    check("badidx_rows_written", FrameData, {rows_c[3], rows_c[2], rows_c[1], rows_c[0]});
    repeat (6) @(negedge CLK);
    send(32'hFA300000, 0, e);

    // Highest legal index with s_valid gaps.
    send_frame(8'd19, rows_b, gaps_b, 1'b0, 1'b1, last);
    check_ready_window();

    // Async reset during the second strobe cycle.
    send_frame(8'd0, rows_a, no_gap, 1'b0, 1'b1, last);
    for (int k = 0; k < 20 && cyc < last + 2; k++) begin
      @(posedge CLK);
      #1;
    end
    #2;
    check("pre_reset_strobe", FrameStrobe, 20'd1);
    resetn = 1'b0;
    #1;
    check("async_rst_strobe", FrameStrobe, 0);
    check("async_rst_data", FrameData, 0);
    @(negedge CLK);
    #2;
    resetn = 1'b1;

    // Clean frame after reset.
    send_frame(8'd7, rows_c, no_gap, 1'b0, 1'b1, last);
    check_ready_window();

`ifdef CONFIG_FRAME_CHECKSUM_EN
    send_frame(8'd3, rows_b, no_gap, 1'b1, 1'b0, last);
    @(negedge CLK);
    check("csum_bad_error", error, 1);
    check("csum_bad_ready", bus.s_ready, 1);
    repeat (6) @(negedge CLK);
    send(32'hFA300000, 0, e);
`endif

    // END produces a single-cycle done pulse.
    send(32'hFA200000, 0, e);
    ex.is_done = 1'b1;
    ex.strobe  = '0;
    ex.data    = '0;
    ex.start   = e;
    sb.push_back(ex);
    @(negedge CLK);
    check("done_pulse", done, 1);
    check("done_no_error", error, 0);
    @(negedge CLK);
    check("done_one_cycle", done, 0);

    repeat (8) @(negedge CLK);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
